// File: rtl/ifetch_pkg.sv
// Shared types and sizing constants for the instruction fetch path.
// The cache and decoder import the same constants, so widths agree across blocks.
package ifetch_pkg;

    localparam int ICACHE_DEPTH  = 1024;
    localparam int ICACHE_ADDR_W = $clog2(ICACHE_DEPTH);

    localparam int INS_LEN    = 54;
    localparam int ADDR_W     = ICACHE_ADDR_W;
    localparam int CNT_W      = ADDR_W + 1;   // counts 0..ICACHE_DEPTH inclusive
    localparam int FIFO_DEPTH = 4;            // power of two, at least 2

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // One prefetched instruction together with the address it came from.
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INS_LEN-1:0] data;
    } ins_entry_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Bus bundle between the fetch sequencer, the cache control read port and the decoder.
//
// Handshake rules:
//   - Cache port: icache_rd_ctrl_data is combinational from icache_rd_ctrl_addr and is
//     consumed in the same cycle icache_rd_ctrl_en is high. No backpressure on this port.
//   - Decoder port: a transfer happens on every clock edge where ins_valid && ins_ready.
//     While ins_valid is high and ins_ready is low, ins_valid, ins_data and ins_pc hold
//     their values. ins_valid never depends combinationally on ins_ready.
interface instruction_fetch_if;
    import ifetch_pkg::*;

    logic               icache_rd_ctrl_en;
    logic [ADDR_W-1:0]  icache_rd_ctrl_addr;
    logic [INS_LEN-1:0] icache_rd_ctrl_data;

    logic               ins_valid;
    logic [INS_LEN-1:0] ins_data;
    logic [ADDR_W-1:0]  ins_pc;
    logic               ins_ready;

    // Fetch sequencer side.
    modport master (
        output icache_rd_ctrl_en,
        output icache_rd_ctrl_addr,
        input  icache_rd_ctrl_data,
        output ins_valid,
        output ins_data,
        output ins_pc,
        input  ins_ready
    );

    // Cache and decoder side.
    modport slave (
        input  icache_rd_ctrl_en,
        input  icache_rd_ctrl_addr,
        output icache_rd_ctrl_data,
        input  ins_valid,
        input  ins_data,
        input  ins_pc,
        output ins_ready
    );

endinterface

// File: rtl/ins_fifo.sv
// Small synchronous prefetch FIFO. The head is read straight out of the storage
// array, so a pushed word is visible at the head one cycle later at the earliest.
// A push is accepted while full if a pop happens in the same cycle.
module ins_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    input  logic         flush,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign full  = (r_count == (PTR_W+1)'(DEPTH));
    assign empty = (r_count == '0);
    assign head  = r_mem[r_rd_ptr];

    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    // Pointer, count and storage update; flush wins over push and pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch sequencer: walks a contiguous address range through the cache
// control read port, one word per cycle, buffering fetched words in a prefetch FIFO
// that the decoder drains. Reports busy/done and supports a mid-stream flush.
module instruction_fetch
    import ifetch_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   start_pc,
    input  logic [CNT_W-1:0]    ins_count,
    input  logic                flush,
    instruction_fetch_if.master bus,
    output logic                busy,
    output logic                done,
    output fetch_state_t        o_dbg_state
);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [CNT_W-1:0]  r_remaining;
    logic              r_done;

    logic              w_load;
    logic              w_done_nxt;
    logic              w_issue;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    ins_entry_t        w_push_entry;
    ins_entry_t        w_head;

    // A slot is free if the FIFO is not full or the head leaves this cycle.
    assign w_pop   = bus.ins_valid && bus.ins_ready;
    assign w_issue = !flush && (r_state == FETCH) && (r_remaining != '0) && (!w_full || w_pop);

    assign w_push_entry.pc   = r_pc;
    assign w_push_entry.data = bus.icache_rd_ctrl_data;

    assign bus.icache_rd_ctrl_en   = w_issue;
    assign bus.icache_rd_ctrl_addr = r_pc;
    assign bus.ins_valid           = !w_empty;
    assign bus.ins_data            = w_head.data;
    assign bus.ins_pc              = w_head.pc;

    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign o_dbg_state = r_state;

    ins_fifo #(
        .W     ($bits(ins_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_issue),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .flush     (flush),
        .full      (w_full),
        .empty     (w_empty),
        .head      (w_head)
    );

    // Next-state and done decision; flush overrides everything and never pulses done.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_done_nxt  = 1'b0;
        if (flush) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (ins_count != '0) begin
                            w_state_nxt = FETCH;
                            w_load      = 1'b1;
                        end else begin
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (w_issue && (r_remaining == CNT_W'(1))) begin
                        w_state_nxt = DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_empty) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // State register and completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Address and remaining-count counters: loaded on launch, stepped on each issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= '0;
            r_remaining <= '0;
        end else if (w_load) begin
            r_pc        <= start_pc;
            r_remaining <= ins_count;
        end else if (w_issue) begin
            r_pc        <= r_pc + 1'b1;
            r_remaining <= r_remaining - 1'b1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed timing scenarios plus a
// scoreboard of expected {pc, data} deliveries built from the cache contents.
module tb_instruction_fetch;
    import ifetch_pkg::*;

    localparam int ENTRY_W = $bits(ins_entry_t);

    logic               clk;
    logic               rst;
    logic               start;
    logic [ADDR_W-1:0]  start_pc;
    logic [CNT_W-1:0]   ins_count;
    logic               flush;
    logic               busy;
    logic               done;
    fetch_state_t       dbg_state;

    logic [INS_LEN-1:0] cache_mem [ICACHE_DEPTH];
    logic [ENTRY_W-1:0] exp_q [$];

    int n_checks;
    int n_fail;

    instruction_fetch_if bus ();

    instruction_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_pc    (start_pc),
        .ins_count   (ins_count),
        .flush       (flush),
        .bus         (bus.master),
        .busy        (busy),
        .done        (done),
        .o_dbg_state (dbg_state)
    );

    // Behavioural cache: combinational read port.
    assign bus.icache_rd_ctrl_data = cache_mem[bus.icache_rd_ctrl_addr];

    // Clock / reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ADDR_W-1:0] addr_of(input int base, input int off);
        return ADDR_W'((base + off) % ICACHE_DEPTH);
    endfunction

    // Outputs held at reset values while rst is high and just after release.
    task automatic test_reset();
        #2;
        n_checks++;
        if ({bus.icache_rd_ctrl_en, bus.icache_rd_ctrl_addr, bus.ins_valid, bus.ins_data,
             bus.ins_pc, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: en=%0b addr=%0d valid=%0b data=%h pc=%0d busy=%0b done=%0b, required all 0",
                     bus.icache_rd_ctrl_en, bus.icache_rd_ctrl_addr, bus.ins_valid, bus.ins_data,
                     bus.ins_pc, busy, done);
        end
        repeat (2) next_cycle();
        rst = 1'b0;
        #3;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bus.ins_valid !== 1'b0 || dbg_state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_release: busy=%0b done=%0b valid=%0b state=%0d, required 0 0 0 IDLE",
                     busy, done, bus.ins_valid, dbg_state);
        end
        next_cycle();
    endtask

    // start_pc=5, ins_count=3: exact cycle-by-cycle timing from the launch cycle.
    task automatic test_basic();
        logic              exp_en, exp_valid, exp_done, exp_busy;
        logic [ADDR_W-1:0] exp_pc;
        for (int c = 0; c <= 8; c++) begin
            start            = (c == 0);
            start_pc         = 10'd5;
            ins_count        = 11'd3;
            bus.ins_ready    = 1'b1;
            #4;
            exp_en    = (c >= 1 && c <= 3);
            exp_valid = (c >= 2 && c <= 4);
            exp_done  = (c == 6);
            exp_busy  = (c >= 1 && c <= 5);
            n_checks++;
            if (bus.icache_rd_ctrl_en !== exp_en) begin
                n_fail++;
                $display("FAIL basic_en c=%0d: got %0b, required %0b", c, bus.icache_rd_ctrl_en, exp_en);
            end
            if (exp_en) begin
                n_checks++;
                if (bus.icache_rd_ctrl_addr !== addr_of(5, c - 1)) begin
                    n_fail++;
                    $display("FAIL basic_addr c=%0d: got %0d, required %0d", c, bus.icache_rd_ctrl_addr, addr_of(5, c - 1));
                end
            end
            n_checks++;
            if (bus.ins_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL basic_valid c=%0d: got %0b, required %0b", c, bus.ins_valid, exp_valid);
            end
            if (exp_valid) begin
                exp_pc = addr_of(5, c - 2);
                n_checks++;
                if (bus.ins_pc !== exp_pc || bus.ins_data !== cache_mem[exp_pc]) begin
                    n_fail++;
                    $display("FAIL basic_head c=%0d: got pc=%0d data=%h, required pc=%0d data=%h",
                             c, bus.ins_pc, bus.ins_data, exp_pc, cache_mem[exp_pc]);
                end
            end
            n_checks++;
            if (done !== exp_done || busy !== exp_busy) begin
                n_fail++;
                $display("FAIL basic_status c=%0d: got done=%0b busy=%0b, required done=%0b busy=%0b",
                         c, done, busy, exp_done, exp_busy);
            end
            next_cycle();
        end
        start = 1'b0;
    endtask

    // Generic program run against the scoreboard.
    // mode 0: ready always high; 1: ready low for cycles 0..10; 2: random ready.
    task automatic run_program(input string name, input int pc0, input int cnt, input int mode,
                               input int restart_at, input int budget);
        int                 c;
        int                 reads;
        bit                 seen_done;
        bit                 prev_hold;
        logic [ENTRY_W-1:0] prev_head;
        logic [ENTRY_W-1:0] exp_e;
        logic [ENTRY_W-1:0] got_e;
        exp_q.delete();
        for (int i = 0; i < cnt; i++) begin
            exp_q.push_back({addr_of(pc0, i), cache_mem[addr_of(pc0, i)]});
        end
        c         = 0;
        reads     = 0;
        seen_done = 1'b0;
        prev_hold = 1'b0;
        prev_head = '0;
        while (!seen_done && c < budget) begin
            start     = (c == 0) || (c == restart_at);
            start_pc  = (c == 0) ? ADDR_W'(pc0) : 10'd900;
            ins_count = (c == 0) ? CNT_W'(cnt) : 11'd5;
            case (mode)
                0:       bus.ins_ready = 1'b1;
                1:       bus.ins_ready = (c > 10);
                default: bus.ins_ready = ($urandom_range(0, 3) != 0);
            endcase
            #4;
            got_e = {bus.ins_pc, bus.ins_data};
            if (prev_hold) begin
                n_checks++;
                if (bus.ins_valid !== 1'b1 || got_e !== prev_head) begin
                    n_fail++;
                    $display("FAIL %s_stable c=%0d: got valid=%0b head=%h, required 1 %h",
                             name, c, bus.ins_valid, got_e, prev_head);
                end
            end
            if (bus.icache_rd_ctrl_en === 1'b1) begin
                n_checks++;
                if (bus.icache_rd_ctrl_addr !== addr_of(pc0, reads) || reads >= cnt) begin
                    n_fail++;
                    $display("FAIL %s_read c=%0d: got addr=%0d read#%0d, required addr=%0d within %0d reads",
                             name, c, bus.icache_rd_ctrl_addr, reads, addr_of(pc0, reads), cnt);
                end
                reads++;
            end
            if (mode == 0 && c >= 1 && c <= cnt) begin
                n_checks++;
                if (bus.icache_rd_ctrl_en !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s_bubble c=%0d: got en=%0b, required 1", name, c, bus.icache_rd_ctrl_en);
                end
            end
            if (mode == 1 && c == 10) begin
                n_checks++;
                if (reads != FIFO_DEPTH || bus.icache_rd_ctrl_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s_stall: got reads=%0d en=%0b, required %0d 0",
                             name, reads, bus.icache_rd_ctrl_en, FIFO_DEPTH);
                end
            end
            if (mode == 1 && c == 11) begin
                n_checks++;
                if (bus.icache_rd_ctrl_en !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s_resume: got en=%0b, required 1", name, bus.icache_rd_ctrl_en);
                end
            end
            if (bus.ins_valid === 1'b1 && bus.ins_ready === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s_extra c=%0d: got pc=%0d, required no more deliveries", name, c, bus.ins_pc);
                end else begin
                    exp_e = exp_q.pop_front();
                    if (got_e !== exp_e) begin
                        n_fail++;
                        $display("FAIL %s_deliver c=%0d: got %h, required %h", name, c, got_e, exp_e);
                    end
                end
            end
            if (done === 1'b1) begin
                seen_done = 1'b1;
                n_checks++;
                if (busy !== 1'b0 || (mode == 0 && c != cnt + 3)) begin
                    n_fail++;
                    $display("FAIL %s_done: got cycle=%0d busy=%0b, required busy=0 (cycle %0d when unstalled)",
                             name, c, busy, cnt + 3);
                end
            end
            prev_hold = bus.ins_valid && !bus.ins_ready;
            prev_head = got_e;
            next_cycle();
            c++;
        end
        start = 1'b0;
        n_checks++;
        if (!seen_done || exp_q.size() != 0 || reads != cnt) begin
            n_fail++;
            $display("FAIL %s_complete: got done=%0b left=%0d reads=%0d, required 1 0 %0d",
                     name, seen_done, exp_q.size(), reads, cnt);
        end
    endtask

    // Flush on the 3rd cycle of a 10-instruction run, then a clean relaunch.
    task automatic test_flush();
        for (int c = 0; c <= 7; c++) begin
            start         = (c == 0);
            start_pc      = 10'd40;
            ins_count     = 11'd10;
            flush         = (c == 3);
            bus.ins_ready = 1'b1;
            #4;
            if (c >= 1 && c <= 3) begin
                n_checks++;
                if (bus.icache_rd_ctrl_en !== logic'(c != 3)) begin
                    n_fail++;
                    $display("FAIL flush_en c=%0d: got %0b, required %0b", c, bus.icache_rd_ctrl_en, c != 3);
                end
            end
            if (c >= 4) begin
                n_checks++;
                if (bus.ins_valid !== 1'b0 || busy !== 1'b0 || dbg_state !== IDLE || bus.icache_rd_ctrl_en !== 1'b0) begin
                    n_fail++;
                    $display("FAIL flush_idle c=%0d: got valid=%0b busy=%0b state=%0d en=%0b, required 0 0 IDLE 0",
                             c, bus.ins_valid, busy, dbg_state, bus.icache_rd_ctrl_en);
                end
            end
            n_checks++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_done c=%0d: got %0b, required 0", c, done);
            end
            next_cycle();
        end
        start = 1'b0;
        flush = 1'b0;
        test_basic();
    endtask

    // Zero-length launch: no read, never busy, done on the next cycle.
    task automatic test_zero();
        for (int c = 0; c <= 3; c++) begin
            start         = (c == 0);
            start_pc      = 10'd7;
            ins_count     = 11'd0;
            bus.ins_ready = 1'b1;
            #4;
            n_checks++;
            if (bus.icache_rd_ctrl_en !== 1'b0 || busy !== 1'b0 || done !== logic'(c == 1)) begin
                n_fail++;
                $display("FAIL zero_count c=%0d: got en=%0b busy=%0b done=%0b, required 0 0 %0b",
                         c, bus.icache_rd_ctrl_en, busy, done, c == 1);
            end
            next_cycle();
        end
        start = 1'b0;
    endtask

    // start together with flush is ignored.
    task automatic test_start_flush();
        for (int c = 0; c <= 3; c++) begin
            start     = (c == 0);
            flush     = (c == 0);
            start_pc  = 10'd60;
            ins_count = 11'd4;
            #4;
            n_checks++;
            if (bus.icache_rd_ctrl_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL start_flush c=%0d: got en=%0b busy=%0b done=%0b, required 0 0 0",
                         c, bus.icache_rd_ctrl_en, busy, done);
            end
            next_cycle();
        end
        start = 1'b0;
        flush = 1'b0;
    endtask

    // Asynchronous reset in the middle of a run: immediate return, no done.
    task automatic test_reset_mid();
        start         = 1'b1;
        start_pc      = 10'd200;
        ins_count     = 11'd10;
        bus.ins_ready = 1'b0;
        next_cycle();
        start = 1'b0;
        repeat (2) next_cycle();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b0 || bus.ins_valid !== 1'b0 || bus.icache_rd_ctrl_en !== 1'b0 ||
            bus.icache_rd_ctrl_addr !== '0 || bus.ins_pc !== '0 || bus.ins_data !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got busy=%0b valid=%0b en=%0b addr=%0d pc=%0d data=%h, required all 0",
                     busy, bus.ins_valid, bus.icache_rd_ctrl_en, bus.icache_rd_ctrl_addr, bus.ins_pc, bus.ins_data);
        end
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #3;
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_after c=%0d: got done=%0b busy=%0b, required 0 0", c, done, busy);
            end
            next_cycle();
        end
    endtask

    initial begin
        rst           = 1'b1;
        start         = 1'b0;
        start_pc      = '0;
        ins_count     = '0;
        flush         = 1'b0;
        bus.ins_ready = 1'b0;
        n_checks      = 0;
        n_fail        = 0;
        for (int i = 0; i < ICACHE_DEPTH; i++) begin
            cache_mem[i] = INS_LEN'({$urandom(), $urandom()});
        end

        test_reset();
        test_basic();
        run_program("wrap", 1022, 4, 0, -1, 50);
        run_program("stall", 100, 20, 1, -1, 200);
        test_flush();
        test_zero();
        run_program("start_busy", 300, 8, 0, 3, 60);
        test_start_flush();
        run_program("random", $urandom_range(0, ICACHE_DEPTH - 1), 1024, 2, -1, 6000);
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
